mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit for the MIPS core.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the architectural HI and LO registers.
- Sits directly upstream of the write-back selection: `hi` and `lo` feed the 32-bit write-back mux inputs used by MFHI/MFLO.
- The control unit stalls the PC on `busy`.

Parameters:
- `XLEN`, 32, operand and HI/LO width.
- `ITER`, 32, CALC iterations (equal to XLEN; one result bit per cycle).

Ports:
- `clk`  input  1  system clock, rising edge
- `rst`  input  1  reset, asynchronous and active-high
- `start`  input  1  operation request, sampled on rising edge
- `op`  input  3  operation code (see package)
- `rs_val`  input  32  operand A (multiplicand, dividend, or MTHI/MTLO data)
- `rt_val`  input  32  operand B (multiplier or divisor)
- `busy`  output  1  operation in progress; new start ignored
- `done`  output  1  one-cycle pulse: HI/LO just updated by a mul/div
- `hi`  output  32  HI register
- `lo`  output  32  LO register

Behaviour:
- Reset (async, `rst`=1): state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, all internal accumulators 0. Any in-flight operation is discarded; HI/LO are not updated from it.
- States: IDLE, CALC, FIX.
- IDLE, `start`=1, op ∈ {MULT, MULTU, DIV, DIVU} (edge E0):
  - Latch operands; go to CALC; iteration count=0; `busy`=1.
  - Signed ops latch absolute values plus the sign flags `neg_q`=signA^signB and `neg_r`=signA.
  - Unsigned ops clear both sign flags.
- IDLE, `start`=1, op=MTHI: `hi`←`rs_val` at E0. `busy` and `done` stay 0. No stall.
- IDLE, `start`=1, op=MTLO: same as MTHI, but writes `lo`.
- IDLE, `start`=1, other op codes: no effect.
- CALC: one step per edge for ITER edges (E1..E32), then go to FIX.
  - Multiply: shift-add over a 64-bit product register, one multiplier bit per edge.
  - Divide: restoring division, one quotient bit per edge, using a 33-bit trial subtract.
- FIX (edge E33):
  - Multiply: product negated (64-bit two's complement) if `neg_q`; `hi`←product[63:32], `lo`←product[31:0].
  - Divide: quotient negated if `neg_q`, remainder negated if `neg_r`; `lo`←quotient, `hi`←remainder.
  - State→IDLE, `busy`→0, `done`=1 for exactly one cycle (E33 to E34).
- Latency: `busy` is high for 33 cycles (after E0 through E33). Results are visible on `hi`/`lo` from E33.
- Start rules:
  - `start` while `busy`=1 is ignored entirely, including MTHI/MTLO.
  - `start` in the `done` cycle is accepted, since the state is already IDLE.
- Division by zero is defined; no exception is raised.
  - DIVU: `lo`=0xFFFFFFFF, `hi`=`rs_val`.
  - DIV, rs ≥ 0: `lo`=0xFFFFFFFF, `hi`=`rs_val`.
  - DIV, rs < 0: `lo`=0x00000001, `hi`=`rs_val`.
  - These fall out of the restoring algorithm plus sign fix; no special path is needed.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
- Signed division truncates toward zero. The remainder takes the dividend's sign.
- Absolute value of 0x80000000 is treated as unsigned 0x80000000.
- `hi`/`lo` outputs are registered. They never change except at E0 (MTHI/MTLO), at FIX, or on reset.

Decomposition:
- Shared package `mdu_pkg`:
  - Op codes: MDU_MULT=3'd0, MDU_MULTU=3'd1, MDU_DIV=3'd2, MDU_DIVU=3'd3, MDU_MTHI=3'd4, MDU_MTLO=3'd5.
  - State encoding: IDLE=2'd0, CALC=2'd1, FIX=2'd2.
  - Constant MDU_LATENCY=33.
- The main decoder uses the same op constants.
- One sub-module is natural: `mdu_step`, combinational. It takes the accumulator, operand, and mul/div select, and produces the next accumulator for one iteration. This keeps the FSM and the datapath separate.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF → after 33 cycles: `done` pulse, `hi`=0xFFFFFFFE, `lo`=0x00000001; `busy` high for exactly 33 cycles.
- MULT rs=0xFFFFFFFD (−3), rt=5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. Then DIV rs=0xFFFFFFF9 (−7), rt=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU rs=7, rt=0 → `lo`=0xFFFFFFFF, `hi`=7. DIV rs=0x80000000, rt=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- MTHI rs=0x12345678 → `hi`=0x12345678 next edge, `busy`/`done` stay 0. MTLO issued while `busy` → `lo` unchanged; the mul/div result still lands at FIX.
- Back-to-back: new DIVU accepted in the `done` cycle → `busy` stays high with no gap; the second result is correct 33 cycles later.
- `rst` asserted mid-CALC (cycle 10) asynchronously → `busy`, `done`, `hi` and `lo` all 0 immediately, before the next clock edge; after release, a fresh MULTU 6×7 gives `lo`=42, `hi`=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   - operation codes driven on mult_div_unit.op by the main decoder
//   - FSM state encoding
//   - fixed latency from accepted start to result (busy cycles)
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    localparam logic [1:0] MDU_IDLE  = 2'd0;
    localparam logic [1:0] MDU_CALC  = 2'd1;
    localparam logic [1:0] MDU_FIX   = 2'd2;

    localparam int MDU_LATENCY = 33;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide datapath (purely combinational).
//   acc      : 2*XLEN accumulator
//              multiply: {partial product high half, remaining multiplier bits}
//              divide  : {partial remainder, remaining dividend / quotient bits}
//   operand  : multiplicand (multiply) or divisor (divide), magnitude only
//   is_div   : 1 selects a restoring-division step, 0 a shift-add step
//   acc_next : accumulator after this iteration
module mdu_step
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    input  logic              is_div,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   trial;
    logic [XLEN+1:0] diff;

    always_comb begin
        // Shift-add: the low bit of acc is the current multiplier bit; the
        // carry out of the add becomes the top bit after the right shift.
        add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});

        // Restoring divide: bring the next dividend bit into the remainder,
        // giving a XLEN+1 bit trial value; an extra MSB on the subtract
        // exposes the borrow.
        trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff  = {1'b0, trial} - {2'b00, operand};

        if (is_div) begin
            if (!diff[XLEN+1]) begin
                // Trial >= divisor: the difference is below the divisor, so it fits XLEN bits.
                acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                // Trial < divisor, so its top bit is necessarily zero.
                acc_next = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_next = {add_sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit for the MIPS core.
// Executes MULT/MULTU/DIV/DIVU over ITER cycles plus one sign-fix cycle and
// handles MTHI/MTLO in a single cycle. Holds the architectural HI/LO registers.
//   clk    : system clock, rising edge
//   rst    : asynchronous active-high reset
//   start  : operation request (ignored while busy)
//   op     : operation code (mdu_pkg)
//   rs_val : operand A (multiplicand, dividend, MTHI/MTLO data)
//   rt_val : operand B (multiplier, divisor)
//   busy   : multiply/divide in progress; the PC is stalled on this
//   done   : one-cycle pulse when HI/LO were just written by a mul/div
//   hi, lo : HI and LO registers
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CNT_W = $clog2(ITER + 1);

    logic [1:0]        state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [2*XLEN-1:0] acc_reg;
    logic [XLEN-1:0]   opb_reg;
    logic              is_div_reg;
    logic              neg_q_reg;
    logic              neg_r_reg;
    logic              done_reg;
    logic [XLEN-1:0]   hi_reg;
    logic [XLEN-1:0]   lo_reg;

    logic              is_muldiv_op;
    logic              is_signed_op;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    mdu_step #(.XLEN(XLEN)) u_step (
        .acc      (acc_reg),
        .operand  (opb_reg),
        .is_div   (is_div_reg),
        .acc_next (acc_next)
    );

    always_comb begin
        is_muldiv_op = (op == MDU_MULT) || (op == MDU_MULTU) ||
                       (op == MDU_DIV)  || (op == MDU_DIVU);
        is_signed_op = (op == MDU_MULT) || (op == MDU_DIV);
        // Negating the most negative value wraps back to itself, which read
        // as unsigned is exactly its magnitude.
        abs_a = (is_signed_op && rs_val[XLEN-1]) ? -rs_val : rs_val;
        abs_b = (is_signed_op && rt_val[XLEN-1]) ? -rt_val : rt_val;

        prod_fix = neg_q_reg ? -acc_reg : acc_reg;
        quo_fix  = neg_q_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
        rem_fix  = neg_r_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= MDU_IDLE;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            opb_reg    <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            done_reg   <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                MDU_IDLE: begin
                    if (start) begin
                        if (is_muldiv_op) begin
                            state_reg  <= MDU_CALC;
                            cnt_reg    <= '0;
                            acc_reg    <= {{XLEN{1'b0}}, abs_a};
                            opb_reg    <= abs_b;
                            is_div_reg <= (op == MDU_DIV) || (op == MDU_DIVU);
                            neg_q_reg  <= is_signed_op && (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
                            neg_r_reg  <= is_signed_op && rs_val[XLEN-1];
                        end else if (op == MDU_MTHI) begin
                            hi_reg <= rs_val;
                        end else if (op == MDU_MTLO) begin
                            lo_reg <= rs_val;
                        end
                    end
                end
                MDU_CALC: begin
                    acc_reg <= acc_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(ITER - 1)) begin
                        state_reg <= MDU_FIX;
                    end
                end
                MDU_FIX: begin
                    if (is_div_reg) begin
                        lo_reg <= quo_fix;
                        hi_reg <= rem_fix;
                    end else begin
                        hi_reg <= prod_fix[2*XLEN-1:XLEN];
                        lo_reg <= prod_fix[XLEN-1:0];
                    end
                    done_reg  <= 1'b1;
                    state_reg <= MDU_IDLE;
                end
                default: state_reg <= MDU_IDLE;
            endcase
        end
    end

    assign busy = (state_reg != MDU_IDLE);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: expected {hi,lo} results are pushed
// to a scoreboard queue when an operation is issued and popped when done pulses.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    mult_div_unit #(.XLEN(32), .ITER(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    // Reference model: returns {hi, lo}.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic signed [63:0] sa64, sb64;
        logic [31:0] q, r;
        sa = a; sb = b; sa64 = sa; sb64 = sb;
        case (o)
            MDU_MULT:  return sa64 * sb64;
            MDU_MULTU: return {32'b0, a} * {32'b0, b};
            MDU_DIV: begin
                if (b == 32'h0) return {a, (a[31] ? 32'h1 : 32'hFFFFFFFF)};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            MDU_DIVU: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: return 64'h0;
        endcase
    endfunction

    // Drive one start pulse across one rising edge; returns at the following negedge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for done, counting negedges on which busy was high.
    task automatic wait_done(output int busy_cycles, output bit seen);
        busy_cycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (busy) busy_cycles++;
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, done, hi, lo} !== 66'b0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, required all 0", busy, done, hi, lo);
        end
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_mul();
        logic [2:0]  t_op[2] = '{MDU_MULTU, MDU_MULT};
        logic [31:0] t_a[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFD};
        logic [31:0] t_b[2]  = '{32'hFFFFFFFF, 32'h00000005};
        logic [63:0] t_e[2]  = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFF1};
        logic [63:0] exp;
        int bc; bit seen;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(t_e[i]);
            issue(t_op[i], t_a[i], t_b[i]);
            wait_done(bc, seen);
            exp = exp_q.pop_front();
            vectors++;
            if (!seen) begin miscompares++; $display("FAIL mul_done[%0d]: done not seen, required a pulse within 40 cycles", i); end
            vectors++;
            if (bc != MDU_LATENCY) begin miscompares++; $display("FAIL mul_busy[%0d]: busy %0d cycles, required %0d", i, bc, MDU_LATENCY); end
            vectors++;
            if ({hi, lo} !== exp) begin miscompares++; $display("FAIL mul_result[%0d]: hi:lo=%h, required %h", i, {hi, lo}, exp); end
            $display("op %0d %h,%h -> hi=%h lo=%h busy_cycles=%0d", t_op[i], t_a[i], t_b[i], hi, lo, bc);
            @(negedge clk);
            vectors++;
            if (done !== 1'b0) begin miscompares++; $display("FAIL done_pulse[%0d]: done=%b one cycle later, required 0", i, done); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  t_op[5] = '{MDU_DIV, MDU_DIVU, MDU_DIV, MDU_DIV, MDU_DIV};
        logic [31:0] t_a[5]  = '{32'hFFFFFFF9, 32'h7, 32'h80000000, 32'hFFFFFFFB, 32'h7};
        logic [31:0] t_b[5]  = '{32'h2, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0};
        logic [63:0] t_e[5]  = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000007_FFFFFFFF, 64'h00000000_80000000,
                                 64'hFFFFFFFB_00000001, 64'h00000007_FFFFFFFF};
        logic [63:0] exp;
        int bc; bit seen;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(t_e[i]);
            issue(t_op[i], t_a[i], t_b[i]);
            wait_done(bc, seen);
            exp = exp_q.pop_front();
            vectors++;
            if (!seen || bc != MDU_LATENCY) begin
                miscompares++;
                $display("FAIL div_timing[%0d]: done_seen=%b busy=%0d cycles, required 1 and %0d", i, seen, bc, MDU_LATENCY);
            end
            vectors++;
            if ({hi, lo} !== exp) begin miscompares++; $display("FAIL div_result[%0d]: hi:lo=%h, required %h", i, {hi, lo}, exp); end
            $display("op %0d %h,%h -> hi=%h lo=%h", t_op[i], t_a[i], t_b[i], hi, lo);
        end
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] lo_before;
        logic [63:0] exp;
        int bc; bit seen;
        lo_before = lo;
        issue(MDU_MTHI, 32'h12345678, 32'h0);
        vectors++;
        if ({hi, lo, busy, done} !== {32'h12345678, lo_before, 2'b00}) begin
            miscompares++;
            $display("FAIL mthi: hi=%h lo=%h busy=%b done=%b, required hi=12345678 lo=%h busy=0 done=0", hi, lo, busy, done, lo_before);
        end
        $display("MTHI 12345678 -> hi=%h", hi);
        issue(MDU_MTLO, 32'hCAFEF00D, 32'h0);
        vectors++;
        if ({hi, lo, busy, done} !== {32'h12345678, 32'hCAFEF00D, 2'b00}) begin
            miscompares++;
            $display("FAIL mtlo: hi=%h lo=%h busy=%b done=%b, required hi=12345678 lo=cafef00d busy=0 done=0", hi, lo, busy, done);
        end
        $display("MTLO cafef00d -> lo=%h", lo);
        // MTLO/MTHI while busy must be dropped.
        exp_q.push_back(64'h00000000_0000000C);
        issue(MDU_MULTU, 32'h3, 32'h4);
        start = 1'b1; op = MDU_MTLO; rs_val = 32'hDEADBEEF;
        @(negedge clk);
        op = MDU_MTHI;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if ({hi, lo} !== {32'h12345678, 32'hCAFEF00D}) begin
            miscompares++;
            $display("FAIL mt_while_busy: hi=%h lo=%h, required hi=12345678 lo=cafef00d", hi, lo);
        end
        wait_done(bc, seen);
        exp = exp_q.pop_front();
        vectors++;
        if (!seen || {hi, lo} !== exp) begin
            miscompares++;
            $display("FAIL mul_after_mt: done_seen=%b hi:lo=%h, required 1 and %h", seen, {hi, lo}, exp);
        end
        $display("MULTU 3,4 (MTLO/MTHI ignored) -> hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp;
        int bc; bit seen;
        exp_q.push_back(64'h00000002_0000000E);
        issue(MDU_DIVU, 32'd100, 32'd7);
        wait_done(bc, seen);
        exp = exp_q.pop_front();
        vectors++;
        if (!seen || {hi, lo} !== exp) begin
            miscompares++;
            $display("FAIL b2b_first: done_seen=%b hi:lo=%h, required 1 and %h", seen, {hi, lo}, exp);
        end
        $display("DIVU 100,7 -> hi=%h lo=%h", hi, lo);
        // Still in the done cycle: issue the next divide now.
        exp_q.push_back(64'h0000000F_0FFFFFFF);
        start = 1'b1; op = MDU_DIVU; rs_val = 32'hFFFFFFFF; rt_val = 32'h10;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept: busy=%b after start in done cycle, required 1", busy); end
        wait_done(bc, seen);
        exp = exp_q.pop_front();
        vectors++;
        if (!seen || bc != MDU_LATENCY || {hi, lo} !== exp) begin
            miscompares++;
            $display("FAIL b2b_second: done_seen=%b busy=%0d hi:lo=%h, required 1, %0d, %h", seen, bc, {hi, lo}, MDU_LATENCY, exp);
        end
        $display("DIVU ffffffff,10 -> hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_async_reset();
        logic [63:0] exp;
        int bc; bit seen;
        exp_q.push_back(model(MDU_MULTU, 32'h1234, 32'h5678));
        issue(MDU_MULTU, 32'h1234, 32'h5678);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({busy, done, hi, lo} !== 66'b0) begin
            miscompares++;
            $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h before next edge, required all 0", busy, done, hi, lo);
        end
        exp_q.delete();
        $display("async reset mid-CALC -> busy=%b hi=%h lo=%h", busy, hi, lo);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(64'd42);
        issue(MDU_MULTU, 32'd6, 32'd7);
        wait_done(bc, seen);
        exp = exp_q.pop_front();
        vectors++;
        if (!seen || {hi, lo} !== exp) begin
            miscompares++;
            $display("FAIL post_reset_mul: done_seen=%b hi:lo=%h, required 1 and %h", seen, {hi, lo}, exp);
        end
        $display("MULTU 6,7 -> hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] a, b;
        logic [63:0] exp;
        int bc; bit seen;
        for (int i = 0; i < 12; i++) begin
            o = 3'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(0, 15));
                1: b = -32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            exp_q.push_back(model(o, a, b));
            issue(o, a, b);
            wait_done(bc, seen);
            exp = exp_q.pop_front();
            vectors++;
            if (!seen || bc != MDU_LATENCY || {hi, lo} !== exp) begin
                miscompares++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: done_seen=%b busy=%0d hi:lo=%h, required 1, %0d, %h",
                         i, o, a, b, seen, bc, {hi, lo}, MDU_LATENCY, exp);
            end
            $display("op %0d %h,%h -> hi=%h lo=%h", o, a, b, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_mthi_mtlo();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
